variable_nodes_seq: RTL and testbench

//  Variable-node (odd layer) update of the min-sum LDPC decoder; feeds check_nodes' prev_proc_elem.
//  Per edge e=(v,c): v2c[e] = sat8( llr[v] + sum of c2v[e'] over edges e' on v, e' != e ).

---
 rtl/variable_nodes_seq_if.sv | 26 ++
 rtl/variable_nodes_seq.sv | 147 ++++++++++++++
 tb/tb_variable_nodes_seq.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/variable_nodes_seq_if.sv
// Bus bundle for the variable-node update block: control handshake plus edge/LLR/message arrays.
// The hard_dec member exists only when HARD_DEC_EN is defined.
interface variable_nodes_seq_if #(
  parameter int N_V = 44,
  parameter int E   = 147
);
  // Handshake: start is sampled only while busy is low. busy rises the cycle after the start
  // is accepted and stays high through the single-cycle done pulse. v2c is valid on and after
  // done. tanner_g/llr/c2v must be held stable from start accept until done.
  logic              start;
  logic              busy;
  logic              done;
  logic        [7:0] tanner_g [E][2];
  logic signed [7:0] llr      [N_V];
  logic signed [7:0] c2v      [E];
  logic signed [7:0] v2c      [E];
`ifdef HARD_DEC_EN
  logic [N_V-1:0]    hard_dec;

  modport master (output start, tanner_g, llr, c2v, input busy, done, v2c, hard_dec);
  modport slave  (input start, tanner_g, llr, c2v, output busy, done, v2c, hard_dec);
`else
  modport master (output start, tanner_g, llr, c2v, input busy, done, v2c);
  modport slave  (input start, tanner_g, llr, c2v, output busy, done, v2c);
`endif
endinterface

// File: rtl/variable_nodes_seq.sv
// Edge-serial variable-node update for the min-sum LDPC decoder: pass 1 accumulates per-VN
// totals, pass 2 emits extrinsic v2c messages. Optional feature macro: HARD_DEC_EN (hard_dec output).
module variable_nodes_seq #(
  parameter int N_V   = 44,
  parameter int N_C   = 12,
  parameter int E     = 147,
  parameter int ACC_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  variable_nodes_seq_if.slave bus,
  output logic [1:0]          dbg_state
);

  localparam int IDX_W = (E > 1) ? $clog2(E) : 1;
  localparam logic        [IDX_W-1:0] LAST_IDX = IDX_W'(E - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO   = ACC_W'(-127);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // -128 is folded onto -127 so the arithmetic stays symmetric.
  function automatic logic signed [ACC_W-1:0] sext_clamp(input logic signed [7:0] x);
    logic signed [7:0] c;
    c = (x == 8'sh80) ? 8'sh81 : x;
    return {{(ACC_W-8){c[7]}}, c};
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] a);
    logic signed [7:0] r;
    if (a > SAT_HI)      r = 8'sh7f;
    else if (a < SAT_LO) r = 8'sh81;
    else                 r = a[7:0];
    return r;
  endfunction

  state_t                   state_q, state_d;
  logic        [IDX_W-1:0]  idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q [N_V];
  logic signed [ACC_W-1:0]  acc_d [N_V];
  logic signed [7:0]        v2c_q [E];
  logic signed [7:0]        v2c_d [E];
`ifdef HARD_DEC_EN
  logic        [N_V-1:0]    hard_dec_q, hard_dec_d;
`endif

  logic        [7:0]        cur_vn;
  logic        [7:0]        cur_cn;
  logic                     edge_ok;
  logic signed [ACC_W-1:0]  cur_c2v;
  logic signed [ACC_W-1:0]  cur_acc;

  // Current edge decode; out-of-range VN/CN indices mark the edge as absent.
  always_comb begin
    cur_vn  = bus.tanner_g[idx_q][0];
    cur_cn  = bus.tanner_g[idx_q][1];
    edge_ok = (32'(cur_vn) < N_V) && (32'(cur_cn) < N_C);
    cur_c2v = sext_clamp(bus.c2v[idx_q]);
    cur_acc = '0;
    for (int i = 0; i < N_V; i++) begin
      if (32'(cur_vn) == i) cur_acc = acc_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    v2c_d   = v2c_q;
`ifdef HARD_DEC_EN
    hard_dec_d = hard_dec_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < N_V; i++) acc_d[i] = sext_clamp(bus.llr[i]);
          idx_d   = '0;
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        for (int i = 0; i < N_V; i++) begin
          if (edge_ok && (32'(cur_vn) == i)) acc_d[i] = acc_q[i] + cur_c2v;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_EMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_EMIT: begin
        // Subtracting the edge's own message leaves the extrinsic sum.
        v2c_d[idx_q] = edge_ok ? sat8(cur_acc - cur_c2v) : 8'sh00;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_DONE;
`ifdef HARD_DEC_EN
          for (int i = 0; i < N_V; i++) hard_dec_d[i] = acc_q[i][ACC_W-1];
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      for (int i = 0; i < N_V; i++) acc_q[i] <= '0;
      for (int e = 0; e < E; e++)   v2c_q[e] <= '0;
`ifdef HARD_DEC_EN
      hard_dec_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      v2c_q   <= v2c_d;
`ifdef HARD_DEC_EN
      hard_dec_q <= hard_dec_d;
`endif
    end
  end

  assign bus.v2c  = v2c_q;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
`ifdef HARD_DEC_EN
  assign bus.hard_dec = hard_dec_q;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_variable_nodes_seq.sv
// Self-checking bench for variable_nodes_seq on a 3-VN / 2-CN / 4-edge graph, against a
// direct extrinsic-sum reference model; hard_dec checks are active when HARD_DEC_EN is defined.
module tb_variable_nodes_seq;
  localparam int N_V   = 3;
  localparam int N_C   = 2;
  localparam int E     = 4;
  localparam int ACC_W = 12;
  localparam int LAT   = 2 * E + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  variable_nodes_seq_if #(.N_V(N_V), .E(E)) bus ();

  variable_nodes_seq #(.N_V(N_V), .N_C(N_C), .E(E), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int t_vn  [E];
  int t_cn  [E];
  int t_llr [N_V];
  int t_c2v [E];

  logic [7:0]     exp_q[$];
  logic [N_V-1:0] hd_exp;
  int             done_q[$];
  logic [63:0]    busy_mask;

  // ---------------- stimulus helpers ----------------
  task automatic load_t1();
    t_vn  = '{0, 1, 1, 2};
    t_cn  = '{0, 0, 1, 1};
    t_llr = '{10, -5, 3};
    t_c2v = '{4, 7, -2, 1};
  endtask

  task automatic apply();
    for (int e = 0; e < E; e++) begin
      bus.tanner_g[e][0] = 8'(t_vn[e]);
      bus.tanner_g[e][1] = 8'(t_cn[e]);
      bus.c2v[e]         = 8'(t_c2v[e]);
    end
    for (int v = 0; v < N_V; v++) bus.llr[v] = 8'(t_llr[v]);
  endtask

  function automatic int clampi(int x);
    return (x == -128) ? -127 : x;
  endfunction

  function automatic int sati(int x);
    return (x > 127) ? 127 : ((x < -127) ? -127 : x);
  endfunction

  function automatic bit edge_ok(int e);
    return (t_vn[e] >= 0) && (t_vn[e] < N_V) && (t_cn[e] >= 0) && (t_cn[e] < N_C);
  endfunction

  // Reference: each message is the channel LLR plus every *other* incoming c2v on the same VN.
  task automatic model();
    int sum;
    int post;
    exp_q.delete();
    for (int e = 0; e < E; e++) begin
      if (edge_ok(e)) begin
        sum = clampi(t_llr[t_vn[e]]);
        for (int e2 = 0; e2 < E; e2++)
          if (e2 != e && edge_ok(e2) && t_vn[e2] == t_vn[e]) sum += clampi(t_c2v[e2]);
        exp_q.push_back(8'(sati(sum)));
      end else begin
        exp_q.push_back(8'h00);
      end
    end
    for (int v = 0; v < N_V; v++) begin
      post = clampi(t_llr[v]);
      for (int e = 0; e < E; e++)
        if (edge_ok(e) && t_vn[e] == v) post += clampi(t_c2v[e]);
      hd_exp[v] = (post < 0);
    end
  endtask

  function automatic logic [63:0] exp_busy(int s);
    logic [63:0] m;
    m = '0;
    for (int c = s + 1; c <= s + LAT; c++) m[c] = 1'b1;
    return m;
  endfunction

  // Start sampled at edge 0; outputs of cycle c are observed at the negedge after edge c-1.
  task automatic run_op(input int second_start, input int budget);
    done_q.delete();
    busy_mask = '0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      bus.start = (c == second_start);
      if (bus.done === 1'b1) done_q.push_back(c);
      if (bus.busy === 1'b1) busy_mask[c] = 1'b1;
    end
    bus.start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b want=0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b want=0", bus.done);
    end
    for (int e = 0; e < E; e++) begin
      checks++;
      if (bus.v2c[e] !== 8'sh00) begin
        failures++; $display("FAIL reset_v2c[%0d] got=%0d want=0", e, bus.v2c[e]);
      end
    end
`ifdef HARD_DEC_EN
    checks++;
    if (bus.hard_dec !== '0) begin
      failures++; $display("FAIL reset_hard_dec got=%b want=0", bus.hard_dec);
    end
`endif
  endtask

  task automatic test_basic();
    int t1 [E];
    int dc;
    t1 = '{10, -7, 2, 3};
    load_t1(); apply(); model();
    run_op(0, LAT + 3);
    dc = (done_q.size() > 0) ? done_q[0] : -1;
    checks++;
    if (done_q.size() != 1 || dc != LAT) begin
      failures++; $display("FAIL basic_done n=%0d cycle=%0d want n=1 cycle=%0d", done_q.size(), dc, LAT);
    end
    checks++;
    if (busy_mask !== exp_busy(0)) begin
      failures++; $display("FAIL basic_busy got=%h want=%h", busy_mask, exp_busy(0));
    end
    for (int e = 0; e < E; e++) begin
      logic [7:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if (bus.v2c[e] !== exp || int'(bus.v2c[e]) != t1[e]) begin
        failures++;
        $display("FAIL basic_v2c[%0d] got=%0d want=%0d", e, bus.v2c[e], $signed(exp));
      end
    end
`ifdef HARD_DEC_EN
    checks++;
    if (bus.hard_dec !== hd_exp || hd_exp !== 3'b000) begin
      failures++; $display("FAIL basic_hard_dec got=%b want=%b", bus.hard_dec, hd_exp);
    end
`endif
  endtask

  task automatic test_saturation();
    load_t1();
    t_llr = '{100, 120, -120};
    t_c2v = '{50, 60, 60, -60};
    apply(); model();
    run_op(0, LAT + 1);
    checks++;
    if (bus.v2c[1] !== 8'sd127) begin
      failures++; $display("FAIL sat_pos got=%0d want=127", bus.v2c[1]);
    end
    for (int e = 0; e < E; e++) begin
      logic [7:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if (bus.v2c[e] !== exp) begin
        failures++; $display("FAIL sat_v2c[%0d] got=%0d want=%0d", e, bus.v2c[e], $signed(exp));
      end
    end
  endtask

  task automatic test_clamp();
    load_t1();
    t_llr[2] = -128;
    t_c2v[3] = -128;
    apply(); model();
    run_op(0, LAT + 1);
    checks++;
    if (bus.v2c[3] !== 8'sh81) begin
      failures++; $display("FAIL clamp_v2c3 got=%0d want=-127", bus.v2c[3]);
    end
    for (int e = 0; e < E; e++) begin
      logic [7:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if (bus.v2c[e] !== exp || bus.v2c[e] === 8'sh80) begin
        failures++; $display("FAIL clamp_v2c[%0d] got=%0d want=%0d", e, bus.v2c[e], $signed(exp));
      end
    end
`ifdef HARD_DEC_EN
    checks++;
    if (bus.hard_dec !== hd_exp) begin
      failures++; $display("FAIL clamp_hard_dec got=%b want=%b", bus.hard_dec, hd_exp);
    end
`endif
  endtask

  task automatic test_start_ignored();
    int dc;
    load_t1(); apply(); model();
    run_op(4, LAT + 4);
    dc = (done_q.size() > 0) ? done_q[0] : -1;
    checks++;
    if (done_q.size() != 1 || dc != LAT) begin
      failures++; $display("FAIL ignored_done n=%0d cycle=%0d want n=1 cycle=%0d", done_q.size(), dc, LAT);
    end
    for (int e = 0; e < E; e++) begin
      logic [7:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if (bus.v2c[e] !== exp) begin
        failures++; $display("FAIL ignored_v2c[%0d] got=%0d want=%0d", e, bus.v2c[e], $signed(exp));
      end
    end
  endtask

  task automatic test_back_to_back();
    int d0, d1;
    load_t1(); apply();
    run_op(LAT + 1, 2 * LAT + 5);
    d0 = (done_q.size() > 0) ? done_q[0] : -1;
    d1 = (done_q.size() > 1) ? done_q[1] : -1;
    checks++;
    if (done_q.size() != 2 || d0 != LAT || d1 != 2 * LAT + 1) begin
      failures++;
      $display("FAIL b2b_done n=%0d c0=%0d c1=%0d want n=2 c0=%0d c1=%0d", done_q.size(), d0, d1, LAT, 2 * LAT + 1);
    end
    checks++;
    if (busy_mask !== (exp_busy(0) | exp_busy(LAT + 1))) begin
      failures++; $display("FAIL b2b_busy got=%h want=%h", busy_mask, exp_busy(0) | exp_busy(LAT + 1));
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    int dc;
    load_t1(); apply(); model();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL midrst_ctrl busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    for (int e = 0; e < E; e++) begin
      checks++;
      if (bus.v2c[e] !== 8'sh00) begin
        failures++; $display("FAIL midrst_v2c[%0d] got=%0d want=0", e, bus.v2c[e]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++; $display("FAIL midrst_nodone pulses=%0d want=0", ndone);
    end
    run_op(0, LAT + 1);
    dc = (done_q.size() > 0) ? done_q[0] : -1;
    checks++;
    if (dc != LAT) begin
      failures++; $display("FAIL midrst_rerun_done cycle=%0d want=%0d", dc, LAT);
    end
    for (int e = 0; e < E; e++) begin
      logic [7:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if (bus.v2c[e] !== exp) begin
        failures++; $display("FAIL midrst_v2c_rerun[%0d] got=%0d want=%0d", e, bus.v2c[e], $signed(exp));
      end
    end
  endtask

  task automatic test_out_of_range();
    load_t1();
    t_vn[1] = 7;
    t_cn[2] = 5;
    apply(); model();
    run_op(0, LAT + 1);
    checks++;
    if (bus.v2c[1] !== 8'sh00) begin
      failures++; $display("FAIL oor_v2c1 got=%0d want=0", bus.v2c[1]);
    end
    for (int e = 0; e < E; e++) begin
      logic [7:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if (bus.v2c[e] !== exp) begin
        failures++; $display("FAIL oor_v2c[%0d] got=%0d want=%0d", e, bus.v2c[e], $signed(exp));
      end
    end
  endtask

  task automatic test_hard_dec();
`ifdef HARD_DEC_EN
    load_t1();
    t_llr[0] = -10;
    apply(); model();
    run_op(0, LAT + 1);
    checks++;
    if (bus.hard_dec !== 3'b001 || hd_exp !== 3'b001) begin
      failures++; $display("FAIL hard_dec_neg got=%b want=001", bus.hard_dec);
    end
`endif
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int dc;
      for (int e = 0; e < E; e++) begin
        t_vn[e]  = int'($urandom_range(0, 3));
        t_cn[e]  = int'($urandom_range(0, 2));
        t_c2v[e] = int'($urandom_range(0, 255)) - 128;
      end
      for (int v = 0; v < N_V; v++) t_llr[v] = int'($urandom_range(0, 255)) - 128;
      apply(); model();
      run_op(0, LAT + 1);
      dc = (done_q.size() > 0) ? done_q[0] : -1;
      checks++;
      if (dc != LAT) begin
        failures++; $display("FAIL rand%0d_done cycle=%0d want=%0d", it, dc, LAT);
      end
      for (int e = 0; e < E; e++) begin
        logic [7:0] exp;
        exp = exp_q.pop_front();
        checks++;
        if (bus.v2c[e] !== exp) begin
          failures++; $display("FAIL rand%0d_v2c[%0d] got=%0d want=%0d", it, e, bus.v2c[e], $signed(exp));
        end
      end
`ifdef HARD_DEC_EN
      checks++;
      if (bus.hard_dec !== hd_exp) begin
        failures++; $display("FAIL rand%0d_hard_dec got=%b want=%b", it, bus.hard_dec, hd_exp);
      end
`endif
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < E; i++) begin
      t_vn[i] = 0; t_cn[i] = 0; t_c2v[i] = 0;
    end
    for (int i = 0; i < N_V; i++) t_llr[i] = 0;
    apply();
    test_reset();
    test_basic();
    test_saturation();
    test_clamp();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_out_of_range();
    test_hard_dec();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
